// File: rtl/adder_i4_o3_err_monitor.sv
// adder_i4_o3_err_monitor
// Sweeps all 16 input vectors of a 2-bit + 2-bit approximate adder and compares
// each 3-bit result with the exact sum. It accumulates the maximum absolute
// error, the count of erroneous vectors, the sum of absolute errors, and the
// first vector whose error exceeds ET.
// Parameters:
//   ET                 error threshold; a vector violates when |exact-approx| > ET
//   STOP_ON_VIOLATION  1 = end the sweep at the first violating vector
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           begin a sweep (sampled only in IDLE or DONE)
//   dut_in[3:0]     vector applied to the approximate adder (a = [1:0], b = [3:2])
//   dut_out[2:0]    approximate result from the adder
//   busy, done      sweep in progress / results valid
//   max_err, err_count, sum_err, violation, first_fail_vec   registered metrics
module adder_i4_o3_err_monitor #(
  parameter int unsigned ET                = 1,
  parameter bit          STOP_ON_VIOLATION = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] dut_in,
  input  logic [2:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] max_err,
  output logic [4:0] err_count,
  output logic [6:0] sum_err,
  output logic       violation,
  output logic [3:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [2:0] ET3 = ET[2:0];

  state_t     state;
  logic [3:0] vec;
  logic [2:0] exact;
  logic [3:0] diff;
  logic [3:0] neg_diff;
  logic [2:0] err;
  logic       over;

  // vec is 0 in IDLE and holds the last applied vector in DONE
  assign dut_in = vec;

  always_comb begin
    exact    = {1'b0, vec[1:0]} + {1'b0, vec[3:2]};
    diff     = {1'b0, exact} - {1'b0, dut_out};
    neg_diff = 4'd0 - diff;
    err      = diff[3] ? neg_diff[2:0] : diff[2:0];
    over     = (err > ET3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      max_err        <= '0;
      err_count      <= '0;
      sum_err        <= '0;
      violation      <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= SETTLE;
            vec            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            max_err        <= '0;
            err_count      <= '0;
            sum_err        <= '0;
            violation      <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        SETTLE: state <= CHECK;
        CHECK: begin
          if (err > max_err) max_err <= err;
          err_count <= err_count + {4'd0, (err != 3'd0)};
          sum_err   <= sum_err + {4'd0, err};
          if (over && !violation) begin
            violation      <= 1'b1;
            first_fail_vec <= vec;
          end
          if (vec == 4'hF || (STOP_ON_VIOLATION && over)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            vec   <= vec + 4'd1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_i4_o3_err_monitor.sv
// Testbench for adder_i4_o3_err_monitor: two instances (run-to-end and
// stop-on-violation, both ET=1) driven by a shared lookup-table adder model.
module tb_adder_i4_o3_err_monitor;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] lut [16];

  logic [3:0] in_a, in_b, ff_a, ff_b;
  logic [2:0] out_a, out_b, max_a, max_b;
  logic [4:0] cnt_a, cnt_b;
  logic [6:0] sum_a, sum_b;
  logic       busy_a, busy_b, done_a, done_b, viol_a, viol_b;

  assign out_a = lut[in_a];
  assign out_b = lut[in_b];

  adder_i4_o3_err_monitor #(.ET(1), .STOP_ON_VIOLATION(1'b0)) u_run (
    .clk(clk), .rst(rst), .start(start), .dut_in(in_a), .dut_out(out_a),
    .busy(busy_a), .done(done_a), .max_err(max_a), .err_count(cnt_a),
    .sum_err(sum_a), .violation(viol_a), .first_fail_vec(ff_a));

  adder_i4_o3_err_monitor #(.ET(1), .STOP_ON_VIOLATION(1'b1)) u_stop (
    .clk(clk), .rst(rst), .start(start), .dut_in(in_b), .dut_out(out_b),
    .busy(busy_b), .done(done_b), .max_err(max_b), .err_count(cnt_b),
    .sum_err(sum_b), .violation(viol_b), .first_fail_vec(ff_b));

  typedef struct {
    int          max_e;
    int          cnt;
    int          sum;
    int          viol;
    int          ff;
    int          last;
    int unsigned done_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the truth table with integer arithmetic
  function automatic exp_t model(input bit stop, input int unsigned start_cyc);
    exp_t r;
    int   e;
    r = '{0, 0, 0, 0, 0, 0, 0};
    for (int v = 0; v < 16; v++) begin
      e = (v % 4) + (v / 4) - int'(lut[v]);
      if (e < 0) e = -e;
      if (e > r.max_e) r.max_e = e;
      if (e != 0) r.cnt++;
      r.sum += e;
      if (e > 1 && r.viol == 0) begin
        r.viol = 1;
        r.ff   = v;
      end
      r.last = v;
      if (stop && e > 1) break;
    end
    r.done_cyc = start_cyc + 2 * r.last + 2;
    return r;
  endfunction

  task automatic compare(input string tag, input exp_t e, input int mx, input int cnt,
                         input int sum, input int viol, input int ff, input int din);
    chk({tag, "_cycle"}, int'(cyc), int'(e.done_cyc));
    chk({tag, "_max_err"}, mx, e.max_e);
    chk({tag, "_err_count"}, cnt, e.cnt);
    chk({tag, "_sum_err"}, sum, e.sum);
    chk({tag, "_violation"}, viol, e.viol);
    chk({tag, "_first_fail_vec"}, ff, e.ff);
    chk({tag, "_dut_in"}, din, e.last);
  endtask

  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;
  exp_t ea, eb;

  always @(negedge clk) begin
    chk("excl_run", int'(busy_a && done_a), 0);
    if (done_a && !done_a_q) begin
      if (q_a.size() == 0) chk("unexpected_done_run", 1, 0);
      else begin
        ea = q_a.pop_front();
        compare("run", ea, max_a, cnt_a, sum_a, viol_a, ff_a, in_a);
      end
    end
    done_a_q <= done_a;
  end

  always @(negedge clk) begin
    chk("excl_stop", int'(busy_b && done_b), 0);
    if (done_b && !done_b_q) begin
      if (q_b.size() == 0) chk("unexpected_done_stop", 1, 0);
      else begin
        eb = q_b.pop_front();
        compare("stop", eb, max_b, cnt_b, sum_b, viol_b, ff_b, in_b);
      end
    end
    done_b_q <= done_b;
  end

  task automatic set_mode(input int m);
    for (int v = 0; v < 16; v++) begin
      case (m)
        0:       lut[v] = 3'((v % 4) + (v / 4));
        1:       lut[v] = 3'd0;
        2:       lut[v] = 3'(((v % 4) + (v / 4) + 1) % 8);
        default: lut[v] = 3'($urandom_range(0, 7));
      endcase
    end
  endtask

  // Leaves the caller at the negedge just after the start edge E0
  task automatic start_sweep();
    @(negedge clk);
    q_a.push_back(model(1'b0, cyc + 1));
    q_b.push_back(model(1'b1, cyc + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_both();
    int n = 0;
    while (!(done_a && done_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("timeout_done", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_dut_in"}, in_a, 0);
    chk({tag, "_max_err"}, max_a, 0);
    chk({tag, "_err_count"}, cnt_a, 0);
    chk({tag, "_sum_err"}, sum_a, 0);
    chk({tag, "_violation"}, viol_a, 0);
    chk({tag, "_first_fail_vec"}, ff_a, 0);
    chk({tag, "_stop_all"},
        int'({busy_b, done_b, in_b, max_b, cnt_b, sum_b, viol_b, ff_b}), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_mode(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // exact, tied zero, off-by-one adders
    for (int m = 0; m < 3; m++) begin
      set_mode(m);
      start_sweep();
      wait_both();
    end

    // start pulsed at E4 while busy must be ignored
    set_mode(1);
    start_sweep();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_both();

    // restart from DONE clears metrics at the start edge
    set_mode(0);
    start_sweep();
    chk("restart_busy", busy_a, 1);
    chk("restart_done", done_a, 0);
    chk("restart_err_count", cnt_a, 0);
    chk("restart_max_err", max_a, 0);
    chk("restart_violation", viol_a, 0);
    wait_both();

    // asynchronous abort after E9, then a clean rerun
    set_mode(1);
    start_sweep();
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("abort");
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst = 1'b0;
    start_sweep();
    wait_both();

    // random approximate adders
    repeat (6) begin
      set_mode(3);
      start_sweep();
      wait_both();
    end

    @(negedge clk);
    chk("queue_empty_run", q_a.size(), 0);
    chk("queue_empty_stop", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_i4_o3_err_monitor.md
# adder_i4_o3_err_monitor

Self-checking error-characterisation stage for the 2-bit approximate adder netlists (inputs in0..in3, outputs out0..out2). Sweeps all 16 input vectors into the approximate circuit and consumes its 3-bit result. Compares each result against the exact sum and accumulates error metrics: maximum absolute error, erroneous-vector count, error sum and first violating vector against the error threshold. Sits directly around the combinational approximate adder in the silicon/FPGA evaluation harness, one instance per candidate netlist.

## Interface
- ET, 1, error threshold; a vector violates when |exact − approx| > ET (0..7)
- STOP_ON_VIOLATION, 0, 1 = end the sweep at the first violating vector
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- dut_in  out  4  vector to the approximate adder; bit i drives in<i>
- dut_out  in  3  approximate result; bit i is out<i>
- busy  out  1  sweep in progress
- done  out  1  sweep finished, results valid; held until next start or rst
- max_err  out  3  maximum absolute error seen
- err_count  out  5  number of vectors with nonzero error (0..16)
- sum_err  out  7  sum of absolute errors (0..112)
- violation  out  1  at least one vector exceeded ET
- first_fail_vec  out  4  index of first violating vector; 0 when violation=0

## Operation
- Operand mapping: a = {dut_in[1], dut_in[0]}, b = {dut_in[3], dut_in[2]}; exact = a + b (3 bits, max 6, no overflow); approx = dut_out.
- err = |exact − approx|, computed as an unsigned 3-bit magnitude over 4-bit signed difference; range 0..7.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1: vec←0, all accumulators←0, violation←0, first_fail_vec←0 → SETTLE.
- SETTLE: dut_in = vec; one cycle for the netlist to settle → CHECK.
- CHECK: at the edge ending CHECK, update max_err←max(max_err, err); err_count += (err≠0); sum_err += err; if err>ET and violation=0 then violation←1, first_fail_vec←vec.
- CHECK exit: if vec=15, or STOP_ON_VIOLATION=1 and err>ET, then → DONE. Otherwise vec←vec+1 → SETTLE. vec never wraps during a sweep.
- dut_in is driven from the registered vec in every state. It holds the last applied vector in DONE and 0 in IDLE.
- start while busy is ignored. start held high in DONE restarts every time it is sampled.
- Accumulators are not clamped; widths are sized for worst case (16×7=112).

## Timing
- Reset values: busy=0, done=0, dut_in=0, max_err=0, err_count=0, sum_err=0, violation=0, first_fail_vec=0, state=IDLE.
- rst asserted mid-sweep aborts immediately (asynchronously) to the reset values. No partial results are retained.
- Start sampled at edge E0 → busy=1 after E0. Vector k is accumulated at edge E(2k+2).
- Full sweep: done=1 and busy=0 after E32, i.e. 32 cycles from the start edge.
- Stop-on-violation at vector k: done after E(2k+2). Metrics include vectors 0..k only.
- Outputs are registered. Metrics update only at CHECK edges and are stable while done=1.
- busy and done are never high together.

## Test plan
- Exact-adder model on dut_out, full sweep: done at E32; max_err=0, err_count=0, sum_err=0, violation=0, first_fail_vec=0.
- dut_out tied 0, ET=1: max_err=6, err_count=15, sum_err=48, violation=1, first_fail_vec=2 (a=2, b=0).
- dut_out = (exact+1) mod 8, ET=1: max_err=1, err_count=16, sum_err=16, violation=0.
- STOP_ON_VIOLATION=1, dut_out tied 0, ET=1: done after E6; err_count=2, sum_err=3, max_err=2, first_fail_vec=2, dut_in=2.
- rst pulsed after E9 during a sweep: all outputs return to reset values asynchronously. A new start runs a clean full sweep with results matching an undisturbed run.
- start pulsed at E4 mid-sweep: ignored, with completion still at E32. A second start in DONE clears the metrics and reruns the sweep.
